// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU
//
// Optional build macro: SEQ_DIVIDER_FAST_SPECIAL_EN
//   When defined, divide-by-zero and signed-overflow operations skip CALC
//   and complete two cycles after start. Results are the same in both builds.
//
// Ports:
//   clk_i       in   1      clock, rising edge
//   reset_i     in   1      synchronous active-low reset
//   start_i     in   1      launch request, sampled only in IDLE
//   kill_i      in   1      flush; aborts the operation in flight
//   op_i        in   2      00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend_i  in   WIDTH  numerator, captured on accepted start
//   divisor_i   in   WIDTH  denominator, captured on accepted start
//   busy_o      out  1      operation in flight
//   done_o      out  1      one-cycle pulse, result_o valid
//   result_o    out  WIDTH  quotient or remainder, held until next result
module seq_divider #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic             kill_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] divisor_q;
   logic [WIDTH-1:0] dividend_q;
   logic             is_rem;
   logic             neg_quo;
   logic             neg_rem;
   logic             div_zero;
   logic             sig_ovf;

   // Operand decode at the start boundary
   logic             in_signed;
   logic             dvd_neg;
   logic             dsr_neg;
   logic [WIDTH-1:0] dvd_abs;
   logic [WIDTH-1:0] dsr_abs;
   logic             start_zero;
   logic             start_ovf;

   always_comb begin
      in_signed  = ~op_i[0];
      dvd_neg    = in_signed & dividend_i[WIDTH-1];
      dsr_neg    = in_signed & divisor_i[WIDTH-1];
      // -MOST_NEG wraps to itself, which read unsigned is exactly 2^(WIDTH-1)
      dvd_abs    = dvd_neg ? -dividend_i : dividend_i;
      dsr_abs    = dsr_neg ? -divisor_i : divisor_i;
      start_zero = (divisor_i == '0);
      start_ovf  = in_signed && (dividend_i == MOST_NEG) && (divisor_i == '1);
   end

   // One restoring step: rem stays below the divisor, so the shifted value
   // and the signed difference both fit in WIDTH+1 bits.
   logic [WIDTH:0] rem_shift;
   logic [WIDTH:0] trial;

   always_comb begin
      rem_shift = {rem, quo[WIDTH-1]};
      trial     = rem_shift - {1'b0, divisor_q};
   end

   // Sign correction and special-case override applied in FIX
   logic [WIDTH-1:0] quo_fix;
   logic [WIDTH-1:0] rem_fix;
   logic [WIDTH-1:0] result_next;

   always_comb begin
      quo_fix = neg_quo ? -quo : quo;
      rem_fix = neg_rem ? -rem : rem;
      if (div_zero) begin
         quo_fix = '1;
         rem_fix = dividend_q;
      end else if (sig_ovf) begin
         quo_fix = dividend_q;
         rem_fix = '0;
      end
      result_next = is_rem ? rem_fix : quo_fix;
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state      <= S_IDLE;
         count      <= '0;
         rem        <= '0;
         quo        <= '0;
         divisor_q  <= '0;
         dividend_q <= '0;
         is_rem     <= 1'b0;
         neg_quo    <= 1'b0;
         neg_rem    <= 1'b0;
         div_zero   <= 1'b0;
         sig_ovf    <= 1'b0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         result_o   <= '0;
      end else begin
         done_o <= 1'b0;
         case (state)
            S_IDLE: begin
               // kill has priority over a simultaneous start
               if (start_i && !kill_i) begin
                  is_rem     <= op_i[1];
                  neg_quo    <= dvd_neg ^ dsr_neg;
                  neg_rem    <= dvd_neg;
                  div_zero   <= start_zero;
                  sig_ovf    <= start_ovf;
                  dividend_q <= dividend_i;
                  divisor_q  <= dsr_abs;
                  quo        <= dvd_abs;
                  rem        <= '0;
                  count      <= CNT_W'(WIDTH);
                  busy_o     <= 1'b1;
`ifdef SEQ_DIVIDER_FAST_SPECIAL_EN
                  state      <= (start_zero || start_ovf) ? S_FIX : S_CALC;
`else
                  state      <= S_CALC;
`endif
               end
            end
            S_CALC: begin
               if (kill_i) begin
                  busy_o <= 1'b0;
                  state  <= S_IDLE;
               end else begin
                  if (!trial[WIDTH]) begin
                     rem <= trial[WIDTH-1:0];
                     quo <= {quo[WIDTH-2:0], 1'b1};
                  end else begin
                     rem <= rem_shift[WIDTH-1:0];
                     quo <= {quo[WIDTH-2:0], 1'b0};
                  end
                  count <= count - 1'b1;
                  if (count == CNT_W'(1)) begin
                     state <= S_FIX;
                  end
               end
            end
            S_FIX: begin
               busy_o <= 1'b0;
               state  <= S_IDLE;
               if (!kill_i) begin
                  result_o <= result_next;
                  done_o   <= 1'b1;
               end
            end
            default: begin
               busy_o <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider (directed and random)
module tb_seq_divider;

   localparam int W = 32;

   logic         clk;
   logic         reset_i;
   logic         start_i;
   logic         kill_i;
   logic [1:0]   op_i;
   logic [W-1:0] dividend_i;
   logic [W-1:0] divisor_i;
   logic         busy_o;
   logic         done_o;
   logic [W-1:0] result_o;

   int compared;
   int mismatched;

   seq_divider #(.WIDTH(W)) dut (
      .clk_i      (clk),
      .reset_i    (reset_i),
      .start_i    (start_i),
      .kill_i     (kill_i),
      .op_i       (op_i),
      .dividend_i (dividend_i),
      .divisor_i  (divisor_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .result_o   (result_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   // Reference: RISC-V M-extension semantics computed with native arithmetic
   function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      int sa;
      int sb;
      logic [W-1:0] q;
      logic [W-1:0] r;
      sa = a;
      sb = b;
      if (b == 0) begin
         q = '1;
         r = a;
      end else if (op[0] == 1'b0) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = '0;
         end else begin
            q = sa / sb;
            r = sa % sb;
         end
      end else begin
         q = a / b;
         r = a % b;
      end
      return op[1] ? r : q;
   endfunction

   function automatic int exp_lat(input logic [1:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b);
      bit special;
      special = (b == 0) || (op[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef SEQ_DIVIDER_FAST_SPECIAL_EN
      return special ? 2 : W + 2;
`else
      return special ? W + 2 : W + 2;
`endif
   endfunction

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Caller is positioned just after a falling edge; this is cycle 0.
   task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      op_i       = op;
      dividend_i = a;
      divisor_i  = b;
      start_i    = 1'b1;
   endtask

   // Returns the cycle on which done_o was seen (100 if never), the result and busy at cycle 1.
   task automatic wait_done(output int cyc, output logic [W-1:0] res, output logic busy1);
      cyc   = 0;
      busy1 = 1'b0;
      res   = 'x;
      while (cyc < 100) begin
         @(negedge clk);
         start_i = 1'b0;
         cyc++;
         if (cyc == 1) busy1 = busy_o;
         if (done_o) break;
      end
      res = result_o;
   endtask

   task automatic run_check(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] exp);
      int cyc;
      logic [W-1:0] res;
      logic busy1;
      launch(op, a, b);
      wait_done(cyc, res, busy1);
      check({tag, " result"}, res, exp);
      check({tag, " latency"}, W'(cyc), W'(exp_lat(op, a, b)));
   endtask

   initial begin : stim
      int cyc;
      logic [W-1:0] res;
      logic [W-1:0] last_exp;
      logic busy1;
      bit saw_done;
      logic [1:0] rop;
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      compared   = 0;
      mismatched = 0;
      reset_i    = 1'b0;
      start_i    = 1'b0;
      kill_i     = 1'b0;
      op_i       = '0;
      dividend_i = '0;
      divisor_i  = '0;

      repeat (3) @(negedge clk);
      check("reset busy", W'(busy_o), W'(0));
      check("reset done", W'(done_o), W'(0));
      check("reset result", result_o, '0);
      reset_i = 1'b1;
      @(negedge clk);

      // DIVU 100/7 with handshake timing details
      launch(OP_DIVU, 100, 7);
      wait_done(cyc, res, busy1);
      check("divu result", res, 32'd14);
      check("divu latency", W'(cyc), W'(34));
      check("divu busy cycle1", W'(busy1), W'(1));
      check("divu busy at done", W'(busy_o), W'(0));
      @(negedge clk);
      check("divu done pulse width", W'(done_o), W'(0));
      check("divu result held", result_o, 32'd14);

      run_check("remu 100/7", OP_REMU, 100, 7, 32'd2);
      run_check("div -100/7", OP_DIV, -32'sd100, 7, 32'hFFFF_FFF2);
      run_check("rem -100/7", OP_REM, -32'sd100, 7, 32'hFFFF_FFFE);
      run_check("rem 100/-7", OP_REM, 100, -32'sd7, 32'd2);
      run_check("div 5/0", OP_DIV, 5, 0, 32'hFFFF_FFFF);
      run_check("remu x/0", OP_REMU, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF);
      run_check("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      run_check("rem ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
      run_check("divu max/1", OP_DIVU, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF);
      run_check("div min/2", OP_DIV, 32'h8000_0000, 2, 32'hC000_0000);

      // start re-asserted during CALC must be ignored
      launch(OP_DIVU, 100, 7);
      cyc = 0;
      while (cyc < 100) begin
         @(negedge clk);
         cyc++;
         start_i = (cyc == 5);
         if (cyc == 5) begin
            op_i       = OP_DIV;
            dividend_i = 50;
            divisor_i  = 5;
         end
         if (done_o) break;
      end
      start_i = 1'b0;
      check("ignore start result", result_o, 32'd14);
      check("ignore start latency", W'(cyc), W'(34));

      // Back-to-back: second start issued in the done cycle
      launch(OP_DIVU, 1000, 10);
      wait_done(cyc, res, busy1);
      check("b2b first result", res, 32'd100);
      launch(OP_REMU, 1000, 7);
      wait_done(cyc, res, busy1);
      check("b2b second result", res, 32'd6);
      check("b2b second latency", W'(cyc), W'(34));
      last_exp = 32'd6;
      @(negedge clk);

      // kill at cycle 10 of DIVU 1000/3
      launch(OP_DIVU, 1000, 3);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         start_i = 1'b0;
         if (c == 10) kill_i = 1'b1;
      end
      @(negedge clk);
      kill_i = 1'b0;
      check("kill busy", W'(busy_o), W'(0));
      check("kill result kept", result_o, last_exp);
      saw_done = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done_o) saw_done = 1'b1;
      end
      check("kill no done", W'(saw_done), W'(0));

      // kill and start together in IDLE: start dropped
      launch(OP_DIVU, 9, 3);
      kill_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      kill_i  = 1'b0;
      check("kill+start busy", W'(busy_o), W'(0));
      saw_done = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done_o) saw_done = 1'b1;
      end
      check("kill+start no done", W'(saw_done), W'(0));
      check("kill+start result kept", result_o, last_exp);

      // Reset in the middle of an operation
      launch(OP_DIVU, 1000, 3);
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         start_i = 1'b0;
         if (c == 20) reset_i = 1'b0;
      end
      @(negedge clk);
      check("midreset busy", W'(busy_o), W'(0));
      check("midreset result", result_o, '0);
      check("midreset done", W'(done_o), W'(0));
      reset_i = 1'b1;
      @(negedge clk);

      // Randomized ops with special values mixed in
      for (int i = 0; i < 1500; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 7))
            0: rb = '0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = 32'($urandom_range(1, 17));
            3: rb = rb >> $urandom_range(0, 31);
            4: ra = ra >> $urandom_range(0, 31);
            default: ;
         endcase
         launch(rop, ra, rb);
         wait_done(cyc, res, busy1);
         check($sformatf("rand%0d op%0d %h/%h", i, rop, ra, rb), res, model(rop, ra, rb));
         check($sformatf("rand%0d latency", i), W'(cyc), W'(exp_lat(rop, ra, rb)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
